// File: rtl/dual_rail_pkg.sv
// Shared rail codes, four-phase handshake states and the word-completion helper
// used by every dual-rail monitor channel.
package dual_rail_pkg;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  localparam int unsigned DR_MAX_WIDTH = 64;

  typedef enum logic {
    IDLE_NULL,
    WAIT_NULL
  } fp_state_e;

  // Words narrower than DR_MAX_WIDTH are zero-padded; only the low 'width' bits are judged.
  function automatic logic is_complete(input logic [DR_MAX_WIDTH-1:0][1:0] word,
                                       input int unsigned width);
    logic ok;
    ok = 1'b1;
    for (int unsigned b = 0; b < DR_MAX_WIDTH; b++) begin
      if (b < width && (word[b] == DR_NULL || word[b] == DR_ILLEGAL)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dual_rail_stream_monitor_chan.sv
// One monitored dual-rail link: rail synchroniser, FP/TP token decode, token FIFO,
// token counter and sticky flags. Stall timeout is built only with DR_MON_TIMEOUT_EN.
module dual_rail_chan_decoder
  import dual_rail_pkg::*;
#(
  parameter              ENC         = "FP",
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0][1:0] in,
  input  logic                  clr_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [15:0]           tok_cnt,
  output logic                  err_illegal,
  output logic                  err_overflow,
  output logic                  err_timeout
);

  localparam bit          IsTp      = (ENC == "TP");
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam logic [AW:0] FullCount = CW'(DEPTH);

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0][1:0]                  s;
  logic [WIDTH-1:0][1:0]                  ref_q;
  logic [WIDTH-1:0][1:0]                  code;
  logic [DR_MAX_WIDTH-1:0][1:0]           codeWide;
  logic [WIDTH-1:0]                       decData;
  logic                                   anyIllegal;
  logic                                   anyActive;
  logic                                   complete;
  logic                                   push;
  logic                                   pop;
  logic                                   full;
  logic                                   doWrite;
  logic                                   overflow;
  fp_state_e                              state_q;
  logic [DEPTH-1:0][WIDTH-1:0]            mem_q;
  logic [AW-1:0]                          wrPtr_q;
  logic [AW-1:0]                          rdPtr_q;
  logic [AW:0]                            count_q;
  logic [AW:0]                            count_d;
  logic [15:0]                            tokCnt_q;
  logic                                   errIll_q;
  logic                                   errOvf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // In TP the per-bit code is the change since the last accepted word, so both
  // encodings share one completion/illegal decode.
  always_comb begin
    code       = '0;
    decData    = '0;
    anyIllegal = 1'b0;
    anyActive  = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      code[b]    = IsTp ? (s[b] ^ ref_q[b]) : s[b];
      decData[b] = code[b][1];
      if (code[b] == DR_ILLEGAL) anyIllegal = 1'b1;
      if (code[b] != DR_NULL)    anyActive  = 1'b1;
    end
    codeWide            = '0;
    codeWide[WIDTH-1:0] = code;
    complete            = is_complete(codeWide, WIDTH);
  end

  assign push      = complete && (IsTp || state_q == IDLE_NULL);
  assign full      = (count_q == FullCount);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign doWrite   = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign count_d   = count_q + CW'(doWrite) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_NULL;
      ref_q   <= '0;
    end else if (IsTp) begin
      if (push) ref_q <= s;
    end else begin
      case (state_q)
        IDLE_NULL: if (push) state_q <= WAIT_NULL;
        WAIT_NULL: if (!anyActive) state_q <= IDLE_NULL;
        default:   state_q <= IDLE_NULL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) begin
        mem_q[wrPtr_q] <= decData;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign out_data = out_valid ? mem_q[rdPtr_q] : '0;

  // A fresh error in the clearing cycle must survive, so set dominates clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokCnt_q <= '0;
      errIll_q <= 1'b0;
      errOvf_q <= 1'b0;
    end else begin
      if (push) tokCnt_q <= tokCnt_q + 16'd1;
      errIll_q <= (errIll_q & ~clr_err) | anyIllegal;
      errOvf_q <= (errOvf_q & ~clr_err) | overflow;
    end
  end

  assign tok_cnt      = tokCnt_q;
  assign err_illegal  = errIll_q;
  assign err_overflow = errOvf_q;

`ifdef DR_MON_TIMEOUT_EN
  localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT);

  logic [TW-1:0] stallCnt_q;
  logic [TW-1:0] stallCnt_d;
  logic          stall;
  logic          errTo_q;

  always_comb begin
    stall      = anyActive && !complete;
    stallCnt_d = stallCnt_q;
    if (!stall) begin
      stallCnt_d = '0;
    end else if (stallCnt_q != TimeoutMax) begin
      stallCnt_d = stallCnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      errTo_q    <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      errTo_q    <= (errTo_q & ~clr_err) | (stall && stallCnt_d == TimeoutMax);
    end
  end

  assign err_timeout = errTo_q;
`else
  // TIMEOUT only matters once the stall counter exists.
  assign err_timeout = (TIMEOUT == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: rtl/dual_rail_stream_monitor.sv
// Multi-channel dual-rail link monitor: one independent decoder per channel, shared
// clr_err. Optional stall timeout is enabled with the DR_MON_TIMEOUT_EN macro.
module dual_rail_stream_monitor #(
  parameter              ENC         = "FP",
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNELS-1:0][WIDTH-1:0][1:0] in,
  output logic [CHANNELS-1:0]                 out_valid,
  input  logic [CHANNELS-1:0]                 out_ready,
  output logic [CHANNELS-1:0][WIDTH-1:0]      out_data,
  output logic [CHANNELS-1:0][15:0]           tok_cnt,
  output logic [CHANNELS-1:0]                 err_illegal,
  output logic [CHANNELS-1:0]                 err_overflow,
  output logic [CHANNELS-1:0]                 err_timeout,
  input  logic                                clr_err
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
    dual_rail_chan_decoder #(
      .ENC         (ENC),
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) uDecoder (
      .clk          (clk),
      .rst_n        (rst_n),
      .in           (in[ch]),
      .clr_err      (clr_err),
      .out_valid    (out_valid[ch]),
      .out_ready    (out_ready[ch]),
      .out_data     (out_data[ch]),
      .tok_cnt      (tok_cnt[ch]),
      .err_illegal  (err_illegal[ch]),
      .err_overflow (err_overflow[ch]),
      .err_timeout  (err_timeout[ch])
    );
  end

endmodule

// File: tb/tb_dual_rail_stream_monitor.sv
// Directed bench for dual_rail_stream_monitor: an FP instance driven from a vector
// table, plus hand sequences for reset, TP decode and (with DR_MON_TIMEOUT_EN) stall.
`timescale 1ns/1ps
module tb_dual_rail_stream_monitor;

  localparam int W  = 8;
  localparam int CH = 2;

  typedef logic [W-1:0][1:0] rail_t;

  typedef struct {
    rail_t       rail0;
    rail_t       rail1;
    logic        ready;
    logic        clr;
    int          hold;
    logic        expValid0;
    logic [7:0]  expData0;
    logic [15:0] expCnt0;
    logic        expIll0;
    logic        expOvf0;
    logic        expValid1;
    logic [7:0]  expData1;
    logic [15:0] expCnt1;
  } vec_t;

  logic                     clk     = 1'b0;
  logic                     rst_n   = 1'b0;
  logic                     clrErr  = 1'b0;
  logic [CH-1:0][W-1:0][1:0] inFp   = '0;
  logic [CH-1:0][W-1:0][1:0] inTp   = '0;
  logic [CH-1:0]            readyFp = '0;
  logic [CH-1:0]            readyTp = '0;
  logic [CH-1:0]            validFp, validTp, illFp, illTp, ovfFp, ovfTp, toFp, toTp;
  logic [CH-1:0][W-1:0]     dataFp, dataTp;
  logic [CH-1:0][15:0]      cntFp, cntTp;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  rail_t w1, w2, w3;
  logic toExp;

  always #5 clk = ~clk;

  dual_rail_stream_monitor #(
    .ENC("FP"), .WIDTH(W), .CHANNELS(CH), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(16)
  ) dutFp (
    .clk(clk), .rst_n(rst_n), .in(inFp), .out_valid(validFp), .out_ready(readyFp),
    .out_data(dataFp), .tok_cnt(cntFp), .err_illegal(illFp), .err_overflow(ovfFp),
    .err_timeout(toFp), .clr_err(clrErr)
  );

  dual_rail_stream_monitor #(
    .ENC("TP"), .WIDTH(W), .CHANNELS(CH), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(16)
  ) dutTp (
    .clk(clk), .rst_n(rst_n), .in(inTp), .out_valid(validTp), .out_ready(readyTp),
    .out_data(dataTp), .tok_cnt(cntTp), .err_illegal(illTp), .err_overflow(ovfTp),
    .err_timeout(toTp), .clr_err(clrErr)
  );

  function automatic rail_t fpWord(input logic [W-1:0] d);
    rail_t w;
    for (int b = 0; b < W; b++) w[b] = d[b] ? 2'b10 : 2'b01;
    return w;
  endfunction

  function automatic rail_t partialWord(input logic [W-1:0] d, input int nbits);
    rail_t w;
    w = fpWord(d);
    for (int b = 0; b < W; b++) if (b >= nbits) w[b] = 2'b00;
    return w;
  endfunction

  function automatic vec_t mkRow(input rail_t r0, input rail_t r1, input logic rdy,
                                 input logic clr, input int hold,
                                 input logic v0, input logic [7:0] d0, input logic [15:0] c0,
                                 input logic i0, input logic o0,
                                 input logic v1, input logic [7:0] d1, input logic [15:0] c1);
    vec_t v;
    v.rail0 = r0; v.rail1 = r1; v.ready = rdy; v.clr = clr; v.hold = hold;
    v.expValid0 = v0; v.expData0 = d0; v.expCnt0 = c0; v.expIll0 = i0; v.expOvf0 = o0;
    v.expValid1 = v1; v.expData1 = d1; v.expCnt1 = c1;
    return v;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    inFp[0] = v.rail0;
    inFp[1] = v.rail1;
    readyFp = {CH{v.ready}};
    clrErr  = v.clr;
    cycles(v.hold);
  endtask

  initial begin
    rail_t nul, ill;
    nul = '0;
    ill = fpWord(8'hA5);
    ill[3] = 2'b11;

    // rail0, rail1, ready, clr, hold | ch0 valid,data,cnt,ill,ovf | ch1 valid,data,cnt
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b0, 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(fpWord(8'hA5), nul, 1'b1, 1'b0, 2, 1'b0, 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(fpWord(8'hA5), nul, 1'b1, 1'b0, 1, 1'b1, 8'hA5, 16'd1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b0, 8'h00, 16'd1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 3, 1'b0, 8'h00, 16'd1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(fpWord(8'h3C), nul, 1'b1, 1'b0, 3, 1'b1, 8'h3C, 16'd2, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 4, 1'b0, 8'h00, 16'd2, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0));
    vecs.push_back(mkRow(fpWord(8'h11), fpWord(8'h22), 1'b1, 1'b0, 3, 1'b1, 8'h11, 16'd3, 1'b0, 1'b0, 1'b1, 8'h22, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 4, 1'b0, 8'h00, 16'd3, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(fpWord(8'h01), nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd4, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd4, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(fpWord(8'h02), nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd5, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd5, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(fpWord(8'h03), nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd6, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd6, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(fpWord(8'h04), nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd7, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd7, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(fpWord(8'h05), nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd8, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b0, 1'b0, 3, 1'b1, 8'h01, 16'd8, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b1, 8'h02, 16'd8, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b1, 8'h03, 16'd8, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b1, 8'h04, 16'd8, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b0, 8'h00, 16'd8, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b1, 1, 1'b0, 8'h00, 16'd8, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(ill, nul, 1'b1, 1'b0, 3, 1'b0, 8'h00, 16'd8, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(ill, nul, 1'b1, 1'b1, 1, 1'b0, 8'h00, 16'd8, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 3, 1'b0, 8'h00, 16'd8, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b1, 1, 1'b0, 8'h00, 16'd8, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 1, 1'b0, 8'h00, 16'd8, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(partialWord(8'h5A, 4), nul, 1'b1, 1'b0, 3, 1'b0, 8'h00, 16'd8, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(fpWord(8'h5A), nul, 1'b1, 1'b0, 3, 1'b1, 8'h5A, 16'd9, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));
    vecs.push_back(mkRow(nul, nul, 1'b1, 1'b0, 4, 1'b0, 8'h00, 16'd9, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1));

    #2;
    checkOutput("reset validFp", 32'(validFp), 32'h0);
    checkOutput("reset cntFp0", 32'(cntFp[0]), 32'h0);
    checkOutput("reset dataFp0", 32'(dataFp[0]), 32'h0);
    checkOutput("reset errFp", 32'({illFp, ovfFp, toFp}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("r%0d valid0", i), 32'(validFp[0]), 32'(vecs[i].expValid0));
      checkOutput($sformatf("r%0d data0", i), 32'(dataFp[0]), 32'(vecs[i].expData0));
      checkOutput($sformatf("r%0d cnt0", i), 32'(cntFp[0]), 32'(vecs[i].expCnt0));
      checkOutput($sformatf("r%0d ill0", i), 32'(illFp[0]), 32'(vecs[i].expIll0));
      checkOutput($sformatf("r%0d ovf0", i), 32'(ovfFp[0]), 32'(vecs[i].expOvf0));
      checkOutput($sformatf("r%0d to0", i), 32'(toFp[0]), 32'h0);
      checkOutput($sformatf("r%0d valid1", i), 32'(validFp[1]), 32'(vecs[i].expValid1));
      checkOutput($sformatf("r%0d data1", i), 32'(dataFp[1]), 32'(vecs[i].expData1));
      checkOutput($sformatf("r%0d cnt1", i), 32'(cntFp[1]), 32'(vecs[i].expCnt1));
      checkOutput($sformatf("r%0d errs1", i), 32'({illFp[1], ovfFp[1]}), 32'h0);
    end
    clrErr = 1'b0;

    // Stall with only the low nibble valid; flag rises on the 16th stalled cycle.
`ifdef DR_MON_TIMEOUT_EN
    toExp = 1'b1;
`else
    toExp = 1'b0;
`endif
    inFp[0] = partialWord(8'h0F, 4);
    cycles(10);
    checkOutput("stall early to0", 32'(toFp[0]), 32'h0);
    cycles(12);
    checkOutput("stall late to0", 32'(toFp[0]), 32'(toExp));
    checkOutput("stall cnt0", 32'(cntFp[0]), 32'd9);
    checkOutput("stall valid0", 32'(validFp[0]), 32'h0);
    inFp[0] = '0;
    cycles(4);
    clrErr = 1'b1;
    cycles(1);
    clrErr = 1'b0;
    checkOutput("stall cleared to0", 32'(toFp[0]), 32'h0);

    // Reset with one token buffered and another inside the synchroniser.
    readyFp = '0;
    inFp[0] = fpWord(8'h66);
    cycles(3);
    checkOutput("prerst valid0", 32'(validFp[0]), 32'h1);
    checkOutput("prerst data0", 32'(dataFp[0]), 32'h66);
    checkOutput("prerst cnt0", 32'(cntFp[0]), 32'd10);
    inFp[0] = '0;
    cycles(3);
    inFp[0] = fpWord(8'h77);
    cycles(2);
    rst_n = 1'b0;
    #1;
    checkOutput("inrst valid0", 32'(validFp[0]), 32'h0);
    checkOutput("inrst data0", 32'(dataFp[0]), 32'h0);
    checkOutput("inrst cnt0", 32'(cntFp[0]), 32'h0);
    inFp = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    checkOutput("postrst valid0", 32'(validFp[0]), 32'h0);
    checkOutput("postrst cnt0", 32'(cntFp[0]), 32'h0);

    // TP: tokens follow each other without a null phase; reference starts at zero.
    readyTp = '0;
    w1 = fpWord(8'h0F);
    inTp[0] = w1;
    cycles(2);
    checkOutput("tp latency valid0", 32'(validTp[0]), 32'h0);
    cycles(1);
    checkOutput("tp t1 valid0", 32'(validTp[0]), 32'h1);
    checkOutput("tp t1 data0", 32'(dataTp[0]), 32'h0F);
    checkOutput("tp t1 cnt0", 32'(cntTp[0]), 32'd1);
    w2 = w1 ^ fpWord(8'hF0);
    inTp[0] = w2;
    cycles(3);
    checkOutput("tp t2 cnt0", 32'(cntTp[0]), 32'd2);
    checkOutput("tp t2 head0", 32'(dataTp[0]), 32'h0F);
    checkOutput("tp t2 ill0", 32'(illTp[0]), 32'h0);
    readyTp = '1;
    cycles(1);
    checkOutput("tp pop1 data0", 32'(dataTp[0]), 32'hF0);
    cycles(1);
    checkOutput("tp pop2 valid0", 32'(validTp[0]), 32'h0);
    checkOutput("tp pop2 data0", 32'(dataTp[0]), 32'h0);
    cycles(3);
    checkOutput("tp steady cnt0", 32'(cntTp[0]), 32'd2);
    w3 = w2 ^ fpWord(8'h5A);
    inTp[0] = w3;
    readyTp = '0;
    cycles(3);
    checkOutput("tp t3 data0", 32'(dataTp[0]), 32'h5A);
    checkOutput("tp t3 cnt0", 32'(cntTp[0]), 32'd3);
    checkOutput("tp ch1 cnt", 32'(cntTp[1]), 32'h0);
    checkOutput("tp errs", 32'({illTp, ovfTp, toTp}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_rail_stream_monitor.md
Name: dual_rail_stream_monitor

Overview:
- Clocked, multi-channel monitor for dual-rail links in two-phase (TP) or four-phase (FP) encoding.
- Per channel, it synchronises the rails, detects codeword completion, and decodes tokens into a per-channel FIFO drained by valid/ready.
- It counts tokens and raises sticky protocol-violation flags.
- It sits on async link taps in both benches and synthesised debug logic, bridging the async domain to the clocked `clk` domain.

Parameters:
- ENC, "FP", encoding: "FP" four-phase return-to-null, "TP" two-phase transition.
- WIDTH, 8, data bits per channel.
- CHANNELS, 2, number of independent links monitored.
- DEPTH, 4, token FIFO entries per channel (power of two, >=2).
- SYNC_STAGES, 2, synchroniser flops per rail (>=2).
- TIMEOUT, 1024, stall threshold in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  sampling clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in  input  [CHANNELS-1:0][WIDTH-1:0][1:0]  dual-rail rails; [1] is the one-rail, [0] is the zero-rail.
- out_valid  output  [CHANNELS-1:0]  FIFO head valid.
- out_ready  input  [CHANNELS-1:0]  consumer accepts head.
- out_data  output  [CHANNELS-1:0][WIDTH-1:0]  decoded token at head.
- tok_cnt  output  [CHANNELS-1:0][15:0]  tokens detected, including dropped ones.
- err_illegal  output  [CHANNELS-1:0]  sticky illegal-code flag.
- err_overflow  output  [CHANNELS-1:0]  sticky FIFO-overflow flag.
- err_timeout  output  [CHANNELS-1:0]  sticky stall flag.
- clr_err  input  1  synchronous clear of all sticky flags.

Behaviour:
- Reset (rst_n=0, async):
  - synchronisers=0; FSM=IDLE_NULL; TP reference word=0; FIFOs empty.
  - out_valid=0, out_data=0, tok_cnt=0, all err_*=0.
  - Reset mid-token discards any partial or buffered tokens.
- Synchroniser output s is the rail word after SYNC_STAGES flops. All decode uses s only.
- FP per-bit codes: 00 NULL, 01 ZERO, 10 ONE, 11 ILLEGAL.
  - complete = every bit ZERO or ONE.
  - null = every bit 00.
  - FSM IDLE_NULL: on complete → push data (bit = s[b][1]), tok_cnt+1, go WAIT_NULL.
  - FSM WAIT_NULL: on null → IDLE_NULL.
  - Partial words: hold state.
- TP: diff[b] = s[b] ^ ref[b].
  - 01 → bit transitioned to 0; 10 → transitioned to 1; 11 → ILLEGAL.
  - complete = every diff in {01,10}. On complete: push data (bit = diff[b][1]), tok_cnt+1, ref <= s.
  - Single state; no null phase.
  - After reset, ref=0, so rails already high at reset release count as transitions.
- ILLEGAL on any bit:
  - err_illegal set; no push that cycle; FSM/ref unchanged.
  - Detection resumes when the code clears.
- Latency: rails stable complete before edge k → push at edge k+SYNC_STAGES → out_valid=1 after that edge.
- FIFO:
  - Pop when out_valid & out_ready.
  - out_data = head entry; out_data=0 whenever empty.
  - Push when full without a same-cycle pop: token dropped, err_overflow set, tok_cnt still increments.
  - Push + pop while full: both succeed, no overflow.
  - Push + pop while empty: token enqueued; out_valid=1 next cycle.
- tok_cnt wraps 0xFFFF → 0x0000.
- Sticky flags: clr_err clears all flags. A new error in the same cycle as clr_err wins (flag stays 1).
- Channels are fully independent. clr_err is shared.

Optional Feature:
- Macro: DR_MON_TIMEOUT_EN.
- With the macro defined:
  - Each channel has a cycle counter that counts while the word is incomplete and nonzero.
    - FP: not null and not complete.
    - TP: diff≠0 and not complete.
  - The counter resets to 0 otherwise.
  - When the counter reaches TIMEOUT, err_timeout[ch] is set and the counter saturates.
- Without the macro: no counter is instantiated and err_timeout is tied to 0.

Decomposition:
- Package dual_rail_pkg holds:
  - rail code constants DR_NULL=2'b00, DR_ZERO=2'b01, DR_ONE=2'b10, DR_ILLEGAL=2'b11;
  - FP state enum {IDLE_NULL, WAIT_NULL};
  - function is_complete(word).
- Sub-module dual_rail_chan_decoder contains one channel: synchroniser, FSM/ref, FIFO, counter, flags, timeout.
  - It is generated CHANNELS times.
  - The top level only fans out parameters and clr_err.

Test Plan:
- FP, WIDTH=8, ch0: drive 0xA5 as rails, then null, then 0x3C; out_ready=1 → out_data 0xA5 at edge SYNC_STAGES after the drive, then 0x3C; tok_cnt=2; no errors.
- TP, WIDTH=8: from reset, toggle rails encoding 0x0F, then 0xF0 without a null phase → two tokens 0x0F and 0xF0; ref tracks; tok_cnt=2.
- FP, bit 3 driven 11 during a token → err_illegal[0]=1, no push, tok_cnt unchanged; assert clr_err with no error → flag clears; clr_err coincident with a new 11 → flag stays 1.
- DEPTH=4, out_ready=0: send 5 FP tokens 1..5 → FIFO holds 1..4, err_overflow=1, tok_cnt=5; raise out_ready → pops 1,2,3,4, then out_valid=0 and out_data=0.
- Channels 0 and 1 driven simultaneously with 0x11 and 0x22 → each channel outputs its own token; counters each 1; no cross-channel effect.
- With DR_MON_TIMEOUT_EN and TIMEOUT=16: FP hold only bits 0..3 valid for 20 cycles → err_timeout[0]=1 at cycle 16 of the stall; without the macro → err_timeout stays 0.
